// File: rtl/cmp_mon_pkg.sv
// Shared types and defaults for the CMP run monitor.
// Holds the FSM encoding and the default parameter values.
package cmp_mon_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3
  } state_t;

  localparam int DEF_NODES          = 4;
  localparam int DEF_INST_W         = 32;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_NOP_HOLD       = 1;
  localparam int DEF_DRAIN_CYCLES   = 5;
  localparam int DEF_TIMEOUT_CYCLES = 500;

  // NOP_HOLD tops out at 15, DRAIN_CYCLES at 255.
  localparam int HOLD_W  = 4;
  localparam int DRAIN_W = 8;

endpackage

// File: rtl/cmp_node_watch.sv
// Per-node NOP watcher: counts consecutive all-zero fetches
// and raises a sticky done flag, capturing the cycle count.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   en              - high while the monitor is in RUN
//   inst            - this node's fetched instruction
//   cycle_count     - current run cycle count
//   done            - sticky completion flag
//   done_cycle      - cycle_count seen when done rose
module cmp_node_watch
  import cmp_mon_pkg::*;
#(
  parameter int INST_W   = DEF_INST_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NOP_HOLD = DEF_NOP_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [INST_W-1:0] inst,
  input  logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic [CNT_W-1:0]  done_cycle
);

  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(NOP_HOLD);

  logic [HOLD_W-1:0] hold;
  logic              is_nop;

  assign is_nop = (inst == '0);

  // Once the run of NOPs is long enough, done rises on
  // the following cycle regardless of the current fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      done       <= 1'b0;
      done_cycle <= '0;
    end else if (en && !done) begin
      if (hold == HOLD_MAX) begin
        done       <= 1'b1;
        done_cycle <= cycle_count;
      end else if (is_nop) begin
        hold <= hold + 1'b1;
      end else begin
        hold <= '0;
      end
    end
  end

endmodule

// File: rtl/cmp_run_monitor.sv
// Run monitor for a CMP: counts run cycles, detects when
// every node idles on NOPs, drains, then pulses dump_en.
// Ports:
//   clk, reset, clear - clock, sync reset, sync restart
//   inst_in           - packed per-node fetched words
//   cycle_count       - run cycles since release
//   node_done         - sticky per-node completion
//   node_done_cycle   - per-node completion timestamps
//   all_done          - high in DRAIN or DONE
//   dump_en           - one-cycle pulse entering DONE
//   timeout           - high in TIMEOUT
//   state             - FSM encoding for debug
module cmp_run_monitor
  import cmp_mon_pkg::*;
#(
  parameter int NODES          = DEF_NODES,
  parameter int INST_W         = DEF_INST_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int NOP_HOLD       = DEF_NOP_HOLD,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NODES*INST_W-1:0] inst_in,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NODES-1:0]        node_done,
  output logic [NODES*CNT_W-1:0]  node_done_cycle,
  output logic                    all_done,
  output logic                    dump_en,
  output logic                    timeout,
  output logic [2:0]              state
);

  localparam logic [CNT_W-1:0] TO_VAL =
    CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam bit NO_DRAIN = (DRAIN_CYCLES == 0);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'(NO_DRAIN ? 0 : DRAIN_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic               rst;
  logic               run;
  logic               nodes_done;
  logic               to_hit;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               dumped;

  // clear behaves exactly like reset.
  assign rst        = reset | clear;
  assign run        = (state_q == ST_RUN);
  assign nodes_done = &node_done;
  assign to_hit     = TO_EN && (cycle_count == TO_VAL);

  for (genvar i = 0; i < NODES; i++) begin : g_node
    cmp_node_watch #(
      .INST_W   (INST_W),
      .CNT_W    (CNT_W),
      .NOP_HOLD (NOP_HOLD)
    ) u_watch (
      .clk         (clk),
      .reset       (rst),
      .en          (run),
      .inst        (inst_in[i*INST_W +: INST_W]),
      .cycle_count (cycle_count),
      .done        (node_done[i]),
      .done_cycle  (node_done_cycle[i*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Completion is checked first so it beats a timeout
  // landing on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (nodes_done)
          state_d = NO_DRAIN ? ST_DONE : ST_DRAIN;
        else if (to_hit)
          state_d = ST_TIMEOUT;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST)
          state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // The count freezes on the cycle RUN is left, so it
  // reports the last cycle actually spent running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      drain_cnt   <= '0;
      dumped      <= 1'b0;
    end else begin
      if (run && state_d == ST_RUN &&
          cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (state_q == ST_DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;
      if (state_q == ST_DONE)
        dumped <= 1'b1;
    end
  end

  always_comb begin
    all_done = 1'b0;
    dump_en  = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      ST_DRAIN: all_done = 1'b1;
      ST_DONE: begin
        all_done = 1'b1;
        dump_en  = !dumped;
      end
      ST_TIMEOUT: timeout = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor.
// Three instances cover default, NOP_HOLD=3 and timeout=22.
module tb_cmp_run_monitor;

  logic         clk = 1'b0;
  logic         reset_a, clear_a, reset_b;
  logic [127:0] inst_a, inst_b;

  logic [31:0]  cc0, cc1, cc2;
  logic [3:0]   nd0, nd1, nd2;
  logic [127:0] ndc0, ndc1, ndc2;
  logic         ad0, ad1, ad2;
  logic         de0, de1, de2;
  logic         to0, to1, to2;
  logic [2:0]   st0, st1, st2;

  int total = 0;
  int bad   = 0;
  int dumps, dumps2;
  logic [31:0] seq [9];
  int cyc [4];

  always #5 clk = ~clk;

  cmp_run_monitor u0 (
    .clk(clk), .reset(reset_a), .clear(clear_a),
    .inst_in(inst_a), .cycle_count(cc0),
    .node_done(nd0), .node_done_cycle(ndc0),
    .all_done(ad0), .dump_en(de0),
    .timeout(to0), .state(st0)
  );

  cmp_run_monitor #(.NOP_HOLD(3), .DRAIN_CYCLES(0)) u1 (
    .clk(clk), .reset(reset_b), .clear(1'b0),
    .inst_in(inst_b), .cycle_count(cc1),
    .node_done(nd1), .node_done_cycle(ndc1),
    .all_done(ad1), .dump_en(de1),
    .timeout(to1), .state(st1)
  );

  cmp_run_monitor #(.TIMEOUT_CYCLES(22)) u2 (
    .clk(clk), .reset(reset_a), .clear(clear_a),
    .inst_in(inst_a), .cycle_count(cc2),
    .node_done(nd2), .node_done_cycle(ndc2),
    .all_done(ad2), .dump_en(de2),
    .timeout(to2), .state(st2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 4; i++) inst_a[i*32 +: 32] = v;
  endtask

  initial begin
    reset_a = 1'b1;
    clear_a = 1'b0;
    reset_b = 1'b1;
    inst_a  = '0;
    inst_b  = '0;
    set_all(32'h13);
    tick;
    tick;
    chk("rst_count", cc0, 0);
    chk("rst_done", nd0, 0);
    chk("rst_ndc", ndc0, 0);
    chk("rst_state", st0, 0);
    chk("rst_all_done", ad0, 0);
    chk("rst_dump", de0, 0);
    chk("rst_timeout", to0, 0);

    // Scenario 1 on u0, scenario 6 on u2
    reset_a = 1'b0;
    for (int t = 1; t <= 23; t++) begin
      if (t == 21) set_all(32'h0);
      tick;
      if (t == 1) chk("s1_first_count", cc0, 1);
      if (t == 21) begin
        chk("s1_count21", cc0, 21);
        chk("s1_not_done21", nd0, 0);
      end
      if (t == 22) begin
        chk("s1_done", nd0, 4'hF);
        for (int i = 0; i < 4; i++)
          chk("s1_ndc", ndc0[i*32 +: 32], 21);
        chk("s1_still_run", st0, 0);
        chk("s1_ad_low", ad0, 0);
      end
      if (t == 23) begin
        chk("s1_drain", st0, 1);
        chk("s1_all_done", ad0, 1);
        chk("s1_count22", cc0, 22);
        chk("s6_drain", st2, 1);
        chk("s6_no_to", to2, 0);
      end
    end
    dumps  = 0;
    dumps2 = 0;
    for (int t = 24; t <= 34; t++) begin
      tick;
      dumps  += int'(de0);
      dumps2 += int'(de2);
      if (t == 27) begin
        chk("s1_dump_early", de0, 0);
        chk("s1_drain_last", st0, 1);
      end
      if (t == 28) begin
        chk("s1_dump", de0, 1);
        chk("s1_done_st", st0, 2);
        chk("s6_dump", de2, 1);
      end
    end
    chk("s1_dump_once", dumps, 1);
    chk("s6_dump_once", dumps2, 1);
    chk("s1_count_hold", cc0, 22);
    chk("s1_terminal", st0, 2);
    chk("s6_to_low", to2, 0);

    // Scenario 3 on u1 (NOP_HOLD=3, no drain)
    seq = '{32'h0, 32'h0, 32'h33, 32'h0, 32'h0,
            32'h0, 32'h77, 32'h77, 32'h77};
    reset_b = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      inst_b[32 +: 32] = seq[t-1];
      tick;
      if (t == 5) chk("s3_pair_ignored", nd1, 4'b1101);
      if (t == 6) chk("s3_not_yet", nd1, 4'b1101);
      if (t == 7) begin
        chk("s3_done", nd1, 4'hF);
        chk("s3_ndc1", ndc1[32 +: 32], 6);
        chk("s3_ndc0", ndc1[0 +: 32], 3);
      end
      if (t == 8) begin
        chk("s3_dump", de1, 1);
        chk("s3_state", st1, 2);
        chk("s3_count", cc1, 7);
      end
      if (t == 9) begin
        chk("s3_dump_off", de1, 0);
        chk("s3_sticky", nd1, 4'hF);
      end
    end

    // Scenario 2: staggered completion
    cyc = '{10, 30, 50, 70};
    reset_a = 1'b1;
    tick;
    chk("s2_rst_state", st0, 0);
    chk("s2_rst_count", cc0, 0);
    reset_a = 1'b0;
    for (int t = 1; t <= 73; t++) begin
      for (int i = 0; i < 4; i++)
        inst_a[i*32 +: 32] =
          (t - 1 >= cyc[i]) ? 32'h0 : 32'h55;
      tick;
      if (t == 30) begin
        chk("s2_u2_to", to2, 1);
        chk("s2_u2_state", st2, 3);
        chk("s2_u2_count", cc2, 22);
      end
      if (t == 71) begin
        chk("s2_three_done", nd0, 4'b0111);
        chk("s2_run71", st0, 0);
      end
      if (t == 72) begin
        chk("s2_all", nd0, 4'hF);
        for (int i = 0; i < 4; i++)
          chk("s2_ndc", ndc0[i*32 +: 32], cyc[i] + 1);
        chk("s2_run72", st0, 0);
      end
      if (t == 73) begin
        chk("s2_drain", st0, 1);
        chk("s2_count", cc0, 72);
      end
    end

    // Scenario 5: clear during drain
    tick;
    chk("s5_in_drain", st0, 1);
    clear_a = 1'b1;
    dumps = 0;
    tick;
    dumps += int'(de0);
    clear_a = 1'b0;
    chk("s5_count", cc0, 0);
    chk("s5_done", nd0, 0);
    chk("s5_ndc", ndc0, 0);
    chk("s5_state", st0, 0);
    chk("s5_all_done", ad0, 0);
    chk("s5_dump", de0, 0);
    chk("s5_u2_to", to2, 0);
    set_all(32'h0);
    for (int t = 1; t <= 15; t++) begin
      tick;
      dumps += int'(de0);
      if (t == 2) chk("s5_ndc_rerun", ndc0[0 +: 32], 1);
    end
    chk("s5_dump_once", dumps, 1);
    chk("s5_final", st0, 2);

    // Scenario 4: node 2 never NOP
    reset_a = 1'b1;
    tick;
    reset_a = 1'b0;
    set_all(32'h0);
    inst_a[64 +: 32] = 32'h99;
    dumps = 0;
    for (int t = 1; t <= 510; t++) begin
      tick;
      dumps += int'(de0);
      if (t == 500) begin
        chk("s4_count500", cc0, 500);
        chk("s4_run500", st0, 0);
      end
      if (t == 501) begin
        chk("s4_state", st0, 3);
        chk("s4_to", to0, 1);
        chk("s4_count", cc0, 500);
      end
    end
    chk("s4_no_dump", dumps, 0);
    chk("s4_nd", nd0, 4'b1011);
    chk("s4_hold", cc0, 500);
    chk("s4_ad", ad0, 0);
    chk("s4_to_sticky", to0, 1);

    // reset and clear together
    reset_a = 1'b1;
    clear_a = 1'b1;
    tick;
    reset_a = 1'b0;
    clear_a = 1'b0;
    chk("rc_state", st0, 0);
    chk("rc_to", to0, 0);
    chk("rc_count", cc0, 0);
    tick;
    chk("rc_first", cc0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
